// File: rtl/meter_time_ctrl.sv
// Parking-meter time controller: button/switch edge detection, per-second
// countdown, saturating balance, BCD digits and display blink control.
module meter_time_ctrl #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int MAX_TIME    = 9999
) (
  input  logic        SYS_CLK,
  input  logic        RESET_N,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        sw_set10,
  input  logic        sw_set205,
  output logic [13:0] time_left,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        blank,
  output logic        tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] HALF_CNT  = CW'(TICK_CYCLES / 2);
  localparam logic [14:0]   MAX15     = 15'(MAX_TIME);

  logic [CW-1:0] cnt;
  logic          half;
  logic [5:0]    in_now;
  logic [5:0]    in_prev;
  logic [5:0]    rise;
  logic          load;
  logic          dec;
  logic [8:0]    add_val;
  logic [14:0]   sum;
  logic [13:0]   next_time;
  logic          blank_next;
  logic [29:0]   bcd;

  assign in_now = {sw_set205, sw_set10, right, left, down, up};
  assign rise   = in_now & ~in_prev;
  assign load   = rise[4] | rise[5];
  assign tick   = (cnt == TICK_LAST);
  assign half   = (cnt >= HALF_CNT);

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Decrement is applied before the add so the clamp sees the combined result.
  always_comb begin
    add_val = '0;
    if (rise[0])      add_val = 9'd60;
    else if (rise[2]) add_val = 9'd120;
    else if (rise[3]) add_val = 9'd180;
    else if (rise[1]) add_val = 9'd300;
    dec = tick && (time_left != '0);
    sum = {1'b0, time_left} - 15'(dec) + 15'(add_val);
    if (rise[4])          next_time = 14'd10;
    else if (rise[5])     next_time = 14'd205;
    else if (sum > MAX15) next_time = MAX15[13:0];
    else                  next_time = sum[13:0];
  end

  always_comb begin
    blank_next = 1'b0;
    if (time_left == '0)          blank_next = half;
    else if (time_left < 14'd180) blank_next = time_left[0];
  end

  // Shift-and-add-3 binary to BCD, fully unrolled.
  always_comb begin
    bcd = '0;
    bcd[13:0] = time_left;
    for (int unsigned i = 0; i < 14; i++) begin
      for (int unsigned d = 0; d < 4; d++) begin
        if (bcd[14+4*d +: 4] >= 4'd5) bcd[14+4*d +: 4] = bcd[14+4*d +: 4] + 4'd3;
      end
      bcd = bcd << 1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_prev   <= '1;
      time_left <= '0;
      digit3    <= '0;
      digit2    <= '0;
      digit1    <= '0;
      digit0    <= '0;
      blank     <= 1'b0;
    end else begin
      in_prev   <= in_now;
      time_left <= next_time;
      digit3    <= bcd[29:26];
      digit2    <= bcd[25:22];
      digit1    <= bcd[21:18];
      digit0    <= bcd[17:14];
      blank     <= blank_next;
    end
  end

endmodule
